// File: rtl/rm_bit_select_ctrl_if.sv
// Circular-buffer read port and selected-bit output stream of the rate-matching
// bit-selection stage. The master side belongs to rm_bit_select_ctrl.
interface rm_bit_select_ctrl_if #(
  parameter int AW = 14
);
  logic          buf_rd_en;
  logic [AW-1:0] buf_addr;
  logic          buf_data;
  logic          buf_null;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output buf_rd_en, buf_addr, out_bit, out_valid, out_last,
    input  buf_data, buf_null, out_ready
  );

  modport slave (
    input  buf_rd_en, buf_addr, out_bit, out_valid, out_last,
    output buf_data, buf_null, out_ready
  );
endinterface

// File: rtl/rm_bit_select_ctrl.sv
// Rate-matching bit selection: reads the circular buffer from the RV offset k0,
// wraps at Kw, drops NULL entries and streams exactly E bits through a small FIFO.
module rm_bit_select_ctrl #(
  parameter int AW = 14,
  parameter int FD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [6:0]          R,
  input  logic [1:0]          rv_idx,
  input  logic [11:0]         E,
  rm_bit_select_ctrl_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int PW = $clog2(FD);

  typedef enum logic [1:0] {IDLE, CALC, RUN, DRAIN} state_t;

  state_t        state;
  logic [6:0]    r_q;
  logic [1:0]    rv_q;
  logic [11:0]   e_q;
  logic [11:0]   out_cnt;
  logic [PW:0]   occ;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [FD-1:0] fifo_mem;
  logic          rd_vld;

  logic [AW-1:0] kw;
  logic [AW-1:0] k0;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_next;
  logic          handshake;
  logic          push;
  logic [PW:0]   occ_next;
  logic [11:0]   cnt_next;
  logic [12:0]   committed;
  logic [12:0]   pending;
  logic          issue;

  assign kw        = AW'(r_q) * AW'(96);
  assign k0        = AW'(r_q) * (AW'(24) * AW'(rv_q) + AW'(2));
  assign addr_inc  = bus.buf_addr + AW'(1);
  assign addr_next = (addr_inc == kw) ? '0 : addr_inc;

  assign bus.out_valid = (occ != '0);
  assign bus.out_bit   = bus.out_valid ? fifo_mem[rd_ptr] : 1'b0;
  assign bus.out_last  = bus.out_valid & (out_cnt == (e_q - 12'd1));

  assign handshake = bus.out_valid & bus.out_ready;
  assign push      = (state == RUN) & rd_vld & ~bus.buf_null;
  assign occ_next  = occ + (PW+1)'(push) - (PW+1)'(handshake);
  assign cnt_next  = out_cnt + 12'(handshake);

  // A read still in flight is counted as if it will be a real bit; if it turns
  // out NULL the shortfall is simply made up by a later read.
  assign committed = 13'(cnt_next) + 13'(occ_next);
  assign pending   = committed + 13'(bus.buf_rd_en);
  assign issue     = (pending < {1'b0, e_q}) &&
                     ((13'(occ_next) + 13'(bus.buf_rd_en)) < 13'(FD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      r_q           <= '0;
      rv_q          <= '0;
      e_q           <= '0;
      out_cnt       <= '0;
      occ           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_mem      <= '0;
      rd_vld        <= 1'b0;
      bus.buf_rd_en <= 1'b0;
      bus.buf_addr  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= bus.buf_rd_en;
      occ    <= occ_next;
      if (handshake) begin
        rd_ptr  <= rd_ptr + PW'(1);
        out_cnt <= cnt_next;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= bus.buf_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      case (state)
        IDLE: begin
          bus.buf_rd_en <= 1'b0;
          if (start) begin
            r_q     <= R;
            rv_q    <= rv_idx;
            e_q     <= E;
            out_cnt <= '0;
            occ     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_vld  <= 1'b0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (e_q == 12'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            bus.buf_rd_en <= 1'b1;
            bus.buf_addr  <= k0;
            state         <= RUN;
          end
        end
        RUN: begin
          if (committed == {1'b0, e_q}) begin
            bus.buf_rd_en <= 1'b0;
            state         <= DRAIN;
          end else begin
            bus.buf_rd_en <= issue;
            if (issue) bus.buf_addr <= addr_next;
          end
        end
        DRAIN: begin
          bus.buf_rd_en <= 1'b0;
          if (handshake && (cnt_next == e_q)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rm_bit_select_ctrl.sv
// Scoreboard bench for rm_bit_select_ctrl: stimulus tasks queue the expected
// read addresses and output bits, negedge monitors pop and compare them.
module tb_rm_bit_select_ctrl;

  localparam int AW = 14;
  localparam int FD = 4;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        start  = 1'b0;
  logic [6:0]  R      = '0;
  logic [1:0]  rv_idx = '0;
  logic [11:0] E      = '0;
  logic        busy;
  logic        done;

  rm_bit_select_ctrl_if #(.AW(AW)) bus ();

  rm_bit_select_ctrl #(.AW(AW), .FD(FD)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .R      (R),
    .rv_idx (rv_idx),
    .E      (E),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic mem_data [0:255];
  logic mem_null [0:255];

  always @(posedge clk) begin
    if (bus.buf_rd_en) begin
      bus.buf_data <= mem_data[bus.buf_addr[7:0]];
      bus.buf_null <= mem_null[bus.buf_addr[7:0]];
    end else begin
      bus.buf_data <= 1'b0;
      bus.buf_null <= 1'b0;
    end
  end

  logic [1:0] exp_out[$];
  int         exp_addr[$];
  int         s1, first_rd, first_vld, last_addr, reads, hs;
  bit         chk_outst = 1'b0;
  bit         hold_valid = 1'b0;
  logic       hold_bit;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every read address and every accepted bit is matched against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.buf_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_addr = int'(bus.buf_addr);
        reads++;
        if (exp_addr.size() == 0) check("read_addr_unexpected", int'(bus.buf_addr), -1);
        else check("read_addr", int'(bus.buf_addr), exp_addr.pop_front());
        if (chk_outst) check("outstanding_le_fd", int'(reads - hs <= FD), 1);
      end
      if (bus.out_valid && first_vld < 0) first_vld = cyc;
      if (hold_valid) check("held_bit_stable", int'({bus.out_valid, bus.out_bit}), int'({1'b1, hold_bit}));
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_bit   = bus.out_bit;
      if (bus.out_valid && bus.out_ready) begin
        hs++;
        if (exp_out.size() == 0) check("out_bit_unexpected", int'({bus.out_bit, bus.out_last}), -1);
        else check("out_bit_last", int'({bus.out_bit, bus.out_last}), int'(exp_out.pop_front()));
      end
    end
  end

  logic [15:0] rdy_pat  = 16'b1100_0000_1110_0101;
  bit          rdy_mode = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        bus.out_ready = rdy_pat[0];
        rdy_pat = {rdy_pat[0], rdy_pat[15:1]};
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  task automatic setNulls(input bit on);
    for (int i = 0; i < 256; i++) mem_null[i] = 1'b0;
    if (on) begin
      for (int i = 0; i < 4; i++) mem_null[i] = 1'b1;
      mem_null[150] = 1'b1;
      mem_null[151] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int r, input int rv, input int e);
    int kw, a, n;
    kw = 96 * r;
    a  = r * (24 * rv + 2);
    n  = 0;
    while (n < e) begin
      exp_addr.push_back(a);
      if (!mem_null[a]) begin
        n++;
        exp_out.push_back({mem_data[a], (n == e) ? 1'b1 : 1'b0});
      end
      a = (a + 1 == kw) ? 0 : a + 1;
    end
    first_rd  = -1;
    first_vld = -1;
    last_addr = -1;
    reads     = 0;
    hs        = 0;
    @(posedge clk);
    #1;
    R      = 7'(r);
    rv_idx = 2'(rv);
    E      = 12'(e);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    s1 = cyc;
    check("busy_in_calc", int'(busy), 1);
  endtask

  function automatic int rel(input int c);
    return (c < 0) ? -1 : c - s1 + 1;
  endfunction

  task automatic checkOutput(input string tag, input int exp_last, input int exp_rd,
                             input int exp_vld, input int exp_done);
    int done_cyc;
    done_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, ".done_seen"}, int'(done_cyc >= 0), 1);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    check({tag, ".last_addr"}, last_addr, exp_last);
    check({tag, ".first_rd_cycle"}, rel(first_rd), exp_rd);
    check({tag, ".first_valid_cycle"}, rel(first_vld), exp_vld);
    if (exp_done > 0) check({tag, ".done_cycle"}, rel(done_cyc), exp_done);
    check({tag, ".bits_left"}, exp_out.size(), 0);
    check({tag, ".addrs_left"}, exp_addr.size(), 0);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, int'(done), 0);
    exp_out.delete();
    exp_addr.delete();
  endtask

  function automatic int outVec();
    return int'({bus.buf_rd_en, bus.buf_addr, bus.out_bit, bus.out_valid,
                 bus.out_last, busy, done});
  endfunction

  initial begin
    setNulls(1'b0);
    for (int i = 0; i < 256; i++) mem_data[i] = 1'(((i * 37) >> 3) & 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outVec(), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    applyStimulus(2, 0, 10);
    checkOutput("t1", 13, 2, 4, 14);

    applyStimulus(2, 3, 60);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    R     = 7'd5;
    E     = 12'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("t2", 15, 2, 4, 64);

    setNulls(1'b1);
    applyStimulus(2, 3, 60);
    checkOutput("t3", 21, 2, 4, 70);
    setNulls(1'b0);

    rdy_mode  = 1'b1;
    chk_outst = 1'b1;
    applyStimulus(2, 0, 10);
    checkOutput("t4", 13, 2, 4, 0);
    rdy_mode  = 1'b0;
    chk_outst = 1'b0;

    applyStimulus(2, 0, 0);
    checkOutput("t5", -1, -1, -1, 2);

    applyStimulus(2, 3, 60);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("t6.async_reset_outputs", outVec(), 0);
    exp_out.delete();
    exp_addr.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(2, 3, 60);
    checkOutput("t6", 15, 2, 4, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rm_bit_select_ctrl.md
# rm_bit_select_ctrl

Controls the bit-selection and pruning stage of rate matching. It computes the redundancy-version start offset k0, reads the circular buffer from k0, wraps at Kw, and drops NULL (dummy) entries. It emits exactly E coded bits on a valid/ready stream. It sits between the circular-buffer read port and the modulator/scrambler input, and starts after the interleaver read phase has filled the buffer.

## Interface
Parameters:
- AW, 14, circular-buffer address width (Kw ≤ 12285)
- FD, 4, output FIFO depth (power of 2, ≥ 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches R, rv_idx, E; ignored unless in IDLE
- R  in  7  interleaver rows (k_pi = 32·R, Kw = 96·R)
- rv_idx  in  2  redundancy version
- E  in  12  number of output bits
- buf_rd_en  out  1  buffer read strobe
- buf_addr  out  AW  buffer read address, valid with buf_rd_en
- buf_data  in  1  read bit, valid the cycle after buf_rd_en
- buf_null  in  1  dummy flag for buf_data, same timing
- out_bit  out  1  selected bit
- out_valid  out  1  out_bit valid
- out_ready  in  1  downstream accept
- out_last  out  1  high with the E-th bit
- busy  out  1  high in CALC/RUN/DRAIN
- done  out  1  one-cycle pulse after the E-th bit handshake

## Operation
- FSM states: IDLE, CALC, RUN, DRAIN.
- IDLE→CALC on start. Latch R, rv_idx, E. Clear all counters and the FIFO.
- CALC (1 cycle):
  - Kw = 96·R. k0 = R·(24·rv_idx + 2). Ncb = Kw, so ceil(Ncb/(8R)) = 12.
  - Both values are 14-bit unsigned. Max k0 = 127·74 = 9398 < Kw.
  - CALC→RUN if E ≠ 0. CALC→IDLE with a done pulse if E = 0.
- RUN:
  - Issue a read when (out_cnt + fifo_occ + inflight) < E and (fifo_occ + inflight) < FD.
  - inflight is 1 if a read was issued the previous cycle.
  - The address starts at k0. Next address = (addr+1 == Kw) ? 0 : addr+1. Wrap is unbounded; multiple laps are allowed when E > Kw − nulls.
  - Returning data with buf_null = 1 is discarded and not counted. Otherwise it is pushed to the FIFO.
  - RUN→DRAIN when out_cnt + fifo_occ = E. No further reads are issued.
- DRAIN: pop the FIFO on out_valid & out_ready. On the E-th handshake, assert done for one cycle and go to IDLE.
- out_cnt (12 bits) increments on each handshake. out_last = out_valid & (out_cnt == E−1).
- out_valid = FIFO non-empty. out_bit = FIFO head.
- start while busy is ignored, with no effect on state.

## Timing
- Reset values: buf_rd_en=0, buf_addr=0, out_bit=0, out_valid=0, out_last=0, busy=0, done=0. FSM=IDLE, FIFO empty, all counters 0.
- start sampled at edge T0: CALC during cycle 1, first buf_rd_en in cycle 2 with buf_addr=k0.
- Data from cycle 2 returns in cycle 3, is written at the end of cycle 3, and gives out_valid in cycle 4. Latency from start to first bit is 4 cycles.
- Throughput is 1 bit/cycle with out_ready=1 and no nulls.
- A null costs one bubble and does not stall the issue pipeline.
- Backpressure:
  - out_valid stays high and out_bit stays stable until accepted.
  - Reads stall once fifo_occ + inflight = FD.
  - No bit is lost or duplicated.
- done is registered and appears in the cycle after the final handshake. busy falls in the same cycle.
- rst asserted mid-operation: all outputs go immediately to their reset values. In-flight buffer data is ignored after release.

## Test plan
1. R=2 (Kw=192), rv=0 (k0=4), E=10, no nulls, out_ready=1 → addresses 4..13 on consecutive cycles from cycle 2. First out_valid in cycle 4. out_last on the 10th bit, then done.
2. R=2, rv=3 (k0=148), E=60, no nulls → addresses 148..191 then 0..15. Output bits equal buffer contents in that order.
3. R=2, rv=3, nulls at addresses 0..3 and 150..151, E=60 → those 6 entries are absent from output. The last address read is 21. Exactly 60 bits are output.
4. Scenario 1 with out_ready toggling pseudo-randomly → identical bit sequence. buf_rd_en never leaves more than FD entries outstanding.
5. E=0, start → done in cycle 2. No buf_rd_en, no out_valid.
6. Assert rst during RUN of scenario 2 → all outputs 0 asynchronously. A new start after release reproduces scenario 2 exactly.
